sram_arbiter: RTL and testbench

//  Shares the single external SRAM between two requesters: the SNES cartridge bus (snes_*) and
//  the AVR bridge (avr_*; address from the serial address register, data from the AVR bus FSM).
//  The block sequences every SRAM cycle: it drives the SRAM strobes, owns the data-bus drive

---
 rtl/sram_arbiter_if.sv | 46 ++++
 rtl/sram_arbiter.sv | 147 ++++++++++++++
 tb/tb_sram_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// Bus bundle for sram_arbiter: both requester handshakes plus the SRAM pins.
//   snes_* / avr_* : req, we, addr, wdata (to arbiter); rdata, ack (from arbiter)
//   sram_*         : addr, dout, drive, ce_n/oe_n/we_n (from arbiter); din (to arbiter)
//   busy           : arbiter not idle
// master = requester/SRAM side, slave = arbiter.
interface sram_arbiter_if #(
   parameter int ADDR_W = 21,
   parameter int DATA_W = 8
);
   logic              snes_req;
   logic              snes_we;
   logic [ADDR_W-1:0] snes_addr;
   logic [DATA_W-1:0] snes_wdata;
   logic [DATA_W-1:0] snes_rdata;
   logic              snes_ack;
   logic              avr_req;
   logic              avr_we;
   logic [ADDR_W-1:0] avr_addr;
   logic [DATA_W-1:0] avr_wdata;
   logic [DATA_W-1:0] avr_rdata;
   logic              avr_ack;
   logic [ADDR_W-1:0] sram_addr;
   logic [DATA_W-1:0] sram_dout;
   logic [DATA_W-1:0] sram_din;
   logic              sram_drive;
   logic              sram_ce_n;
   logic              sram_oe_n;
   logic              sram_we_n;
   logic              busy;

   modport master (
      output snes_req, snes_we, snes_addr, snes_wdata,
      output avr_req, avr_we, avr_addr, avr_wdata,
      output sram_din,
      input  snes_rdata, snes_ack, avr_rdata, avr_ack,
      input  sram_addr, sram_dout, sram_drive, sram_ce_n, sram_oe_n, sram_we_n, busy
   );

   modport slave (
      input  snes_req, snes_we, snes_addr, snes_wdata,
      input  avr_req, avr_we, avr_addr, avr_wdata,
      input  sram_din,
      output snes_rdata, snes_ack, avr_rdata, avr_ack,
      output sram_addr, sram_dout, sram_drive, sram_ce_n, sram_oe_n, sram_we_n, busy
   );
endinterface

// File: rtl/sram_arbiter.sv
// Shares one external SRAM between the SNES cartridge bus and the AVR bridge.
// Sequences each SRAM cycle (strobes, data-bus drive enable, read-data latch).
// SNES has fixed priority; after STARVE_LIMIT consecutive SNES grants with AVR
// waiting, AVR is granted once.
// Ports:
//   avr_clk   : system clock, rising edge
//   avr_reset : synchronous active-high reset
//   bus       : sram_arbiter_if.slave (requester handshakes and SRAM pins)
//
// state  | meaning
// IDLE   | no access; arbitrate and register the winner's command
// ACCESS | ce_n low plus oe_n (read) or we_n (write) for ACCESS_CYCLES cycles
// DONE   | strobes released, write data still driven, winner's ack pulses
module sram_arbiter #(
   parameter int ADDR_W        = 21,
   parameter int DATA_W        = 8,
   parameter int ACCESS_CYCLES = 2,
   parameter int STARVE_LIMIT  = 4
) (
   input logic           avr_clk,
   input logic           avr_reset,
   sram_arbiter_if.slave bus
);
   localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_LIMIT);
   localparam logic [STV_W-1:0] STV_ONE = STV_W'(1);

   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [STV_W-1:0]  starve_q, starve_d;
   logic              sel_avr_q, sel_avr_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] snes_rdata_q, snes_rdata_d;
   logic [DATA_W-1:0] avr_rdata_q, avr_rdata_d;
   logic              grant_avr;
   logic              ce_n, oe_n, we_n, drive, snes_ack, avr_ack;

   always_ff @(posedge avr_clk) begin
      if (avr_reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         starve_q     <= '0;
         sel_avr_q    <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         snes_rdata_q <= '0;
         avr_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         starve_q     <= starve_d;
         sel_avr_q    <= sel_avr_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         snes_rdata_q <= snes_rdata_d;
         avr_rdata_q  <= avr_rdata_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      starve_d     = starve_q;
      sel_avr_d    = sel_avr_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      snes_rdata_d = snes_rdata_q;
      avr_rdata_d  = avr_rdata_q;
      grant_avr    = 1'b0;
      ce_n         = 1'b1;
      oe_n         = 1'b1;
      we_n         = 1'b1;
      drive        = 1'b0;
      snes_ack     = 1'b0;
      avr_ack      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!bus.avr_req)
               starve_d = '0;
            if (bus.snes_req || bus.avr_req) begin
               // AVR wins when SNES is quiet or SNES has used up its run of grants.
               grant_avr = bus.avr_req && (!bus.snes_req || starve_q == STV_MAX);
               sel_avr_d = grant_avr;
               we_d      = grant_avr ? bus.avr_we    : bus.snes_we;
               addr_d    = grant_avr ? bus.avr_addr  : bus.snes_addr;
               wdata_d   = grant_avr ? bus.avr_wdata : bus.snes_wdata;
               if (grant_avr)
                  starve_d = '0;
               else if (bus.avr_req)
                  starve_d = starve_q + STV_ONE;
               cnt_d   = '0;
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            ce_n = 1'b0;
            if (we_q) begin
               we_n  = 1'b0;
               drive = 1'b1;
            end else begin
               oe_n = 1'b0;
            end
            if (cnt_q == CNT_LAST) begin
               if (!we_q) begin
                  if (sel_avr_q)
                     avr_rdata_d = bus.sram_din;
                  else
                     snes_rdata_d = bus.sram_din;
               end
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_DONE: begin
            // Keep driving write data one cycle past we_n rising for hold time.
            drive    = we_q;
            snes_ack = !sel_avr_q;
            avr_ack  = sel_avr_q;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.sram_addr  = addr_q;
   assign bus.sram_dout  = wdata_q;
   assign bus.sram_drive = drive;
   assign bus.sram_ce_n  = ce_n;
   assign bus.sram_oe_n  = oe_n;
   assign bus.sram_we_n  = we_n;
   assign bus.snes_ack   = snes_ack;
   assign bus.avr_ack    = avr_ack;
   assign bus.snes_rdata = snes_rdata_q;
   assign bus.avr_rdata  = avr_rdata_q;
   assign bus.busy       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   typedef struct {
      bit         is_avr;
      bit         is_read;
      logic [7:0] rdata;
      int         cyc;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] exp_snes_rd = 8'h00;
   logic [7:0] exp_avr_rd  = 8'h00;
   logic [7:0] mem [logic [20:0]];

   sram_arbiter_if #(.ADDR_W(21), .DATA_W(8)) bus ();

   sram_arbiter #(
      .ADDR_W(21), .DATA_W(8), .ACCESS_CYCLES(2), .STARVE_LIMIT(4)
   ) dut (
      .avr_clk   (clk),
      .avr_reset (rst),
      .bus       (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [7:0] mem_rd(input logic [20:0] a);
      if (mem.exists(a)) return mem[a];
      return a[7:0] ^ 8'h5A;
   endfunction

   // SRAM model: writes while ce_n/we_n low, read data presented on the falling edge.
   always @(posedge clk)
      if (!bus.sram_ce_n && !bus.sram_we_n) mem[bus.sram_addr] = bus.sram_dout;
   always @(negedge clk)
      bus.sram_din = mem_rd(bus.sram_addr);

   // Scoreboard: every ack pops the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && bus.busy)
         chk("we_oe_excl", {31'd0, !bus.sram_we_n && !bus.sram_oe_n}, 0);
      if (bus.snes_ack || bus.avr_ack) begin
         if (sb.size() == 0) begin
            chk("unexpected_ack", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("ack_side", {31'd0, bus.avr_ack}, {31'd0, e.is_avr});
            chk("ack_single", {31'd0, bus.snes_ack && bus.avr_ack}, 0);
            chk("ack_cycle", cyc, e.cyc);
            if (e.is_read) begin
               if (e.is_avr) exp_avr_rd = e.rdata;
               else          exp_snes_rd = e.rdata;
            end
            chk("snes_rdata", {24'd0, bus.snes_rdata}, {24'd0, exp_snes_rd});
            chk("avr_rdata", {24'd0, bus.avr_rdata}, {24'd0, exp_avr_rd});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input bit is_avr, input bit is_read, input logic [7:0] rd, input int c);
      exp_t e;
      e.is_avr = is_avr; e.is_read = is_read; e.rdata = rd; e.cyc = c;
      sb.push_back(e);
   endtask

   task automatic wait_ack(input bit avr_side, input int max_cyc, input bit drop);
      bit seen = 1'b0;
      for (int i = 0; i < max_cyc && !seen; i++) begin
         tick();
         if (avr_side ? bus.avr_ack : bus.snes_ack) begin
            seen = 1'b1;
            if (drop) begin
               if (avr_side) bus.avr_req = 1'b0;
               else          bus.snes_req = 1'b0;
            end
         end
      end
      if (!seen) chk(avr_side ? "avr_ack_timeout" : "snes_ack_timeout", 0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bus.snes_req = 0; bus.snes_we = 0; bus.snes_addr = '0; bus.snes_wdata = '0;
      bus.avr_req = 0;  bus.avr_we = 0;  bus.avr_addr = '0;  bus.avr_wdata = '0;
      bus.sram_din = '0;
      rst = 1'b1;
      repeat (3) tick();
      chk("rst_ce_n", bus.sram_ce_n, 1);
      chk("rst_oe_n", bus.sram_oe_n, 1);
      chk("rst_we_n", bus.sram_we_n, 1);
      chk("rst_drive", bus.sram_drive, 0);
      chk("rst_addr", bus.sram_addr, 0);
      chk("rst_dout", bus.sram_dout, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_rdata", {bus.snes_rdata, bus.avr_rdata}, 0);
      rst = 1'b0;
      tick();

      // 1: AVR write
      tick(); n = cyc;
      bus.avr_req = 1; bus.avr_we = 1; bus.avr_addr = 21'h0ABCDE; bus.avr_wdata = 8'hEE;
      push(1, 0, 8'h00, n + 3);
      tick();
      chk("w_acc1_ce_n", bus.sram_ce_n, 0);
      chk("w_acc1_we_n", bus.sram_we_n, 0);
      chk("w_acc1_oe_n", bus.sram_oe_n, 1);
      chk("w_acc1_drive", bus.sram_drive, 1);
      chk("w_addr", bus.sram_addr, 21'h0ABCDE);
      chk("w_dout", bus.sram_dout, 8'hEE);
      tick();
      chk("w_acc2_ce_we", {bus.sram_ce_n, bus.sram_we_n}, 0);
      tick();
      chk("w_done_strobes", {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n}, 3'b111);
      chk("w_done_drive", bus.sram_drive, 1);
      chk("w_done_ack", bus.avr_ack, 1);
      bus.avr_req = 0;
      tick();
      chk("w_idle_drive", bus.sram_drive, 0);
      chk("w_idle_busy", bus.busy, 0);
      chk("w_mem", mem_rd(21'h0ABCDE), 8'hEE);

      // 2: AVR read back
      tick(); n = cyc;
      bus.avr_req = 1; bus.avr_we = 0;
      push(1, 1, 8'hEE, n + 3);
      tick();
      chk("r_acc1_oe_we", {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n}, 3'b001);
      chk("r_acc1_drive", bus.sram_drive, 0);
      tick();
      chk("r_acc2_oe_we", {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n}, 3'b001);
      tick();
      chk("r_done_strobes", {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n}, 3'b111);
      chk("r_done_data", bus.avr_rdata, 8'hEE);
      bus.avr_req = 0;
      tick();

      // 3: simultaneous requests, SNES first
      tick(); n = cyc;
      bus.snes_req = 1; bus.snes_we = 0; bus.snes_addr = 21'h000123;
      bus.avr_req = 1;  bus.avr_we = 0;  bus.avr_addr = 21'h0ABCDE;
      push(0, 1, 8'h79, n + 3);
      push(1, 1, 8'hEE, n + 7);
      wait_ack(0, 10, 1);
      wait_ack(1, 10, 1);
      tick();

      // 4: SNES hogs the bus, AVR gets in after four SNES grants
      tick(); n = cyc;
      bus.snes_req = 1; bus.snes_we = 0; bus.snes_addr = 21'h000010;
      bus.avr_req = 1;  bus.avr_we = 1;  bus.avr_addr = 21'h000200; bus.avr_wdata = 8'h33;
      for (int k = 0; k < 4; k++) push(0, 1, 8'h4A, n + 3 + 4 * k);
      push(1, 0, 8'h00, n + 19);
      wait_ack(1, 40, 1);
      bus.snes_req = 0;
      tick();
      chk("starve_mem", mem_rd(21'h000200), 8'h33);

      // 5: reset in the middle of an access
      tick();
      bus.snes_req = 1; bus.snes_we = 1; bus.snes_addr = 21'h000055; bus.snes_wdata = 8'h77;
      tick();
      chk("abort_pre_busy", bus.busy, 1);
      rst = 1'b1;
      exp_snes_rd = 8'h00; exp_avr_rd = 8'h00;
      tick();
      chk("abort_strobes", {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n}, 3'b111);
      chk("abort_drive", bus.sram_drive, 0);
      chk("abort_ack", {bus.snes_ack, bus.avr_ack}, 0);
      chk("abort_busy", bus.busy, 0);
      chk("abort_rdata", {bus.snes_rdata, bus.avr_rdata}, 0);
      bus.snes_req = 0;
      rst = 1'b0;
      repeat (4) tick();

      // 6: back-to-back SNES reads at the address extremes
      tick(); n = cyc;
      bus.snes_req = 1; bus.snes_we = 0; bus.snes_addr = 21'h000000;
      push(0, 1, 8'h5A, n + 3);
      push(0, 1, 8'hA5, n + 7);
      wait_ack(0, 10, 0);
      bus.snes_addr = 21'h1FFFFF;
      wait_ack(0, 10, 1);
      repeat (3) tick();

      chk("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
